multicycle_seq: RTL and testbench

- Multi-cycle instruction sequencer for the KGPminiRISC core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB using the per-opcode control flags produced by the combinational control decoder.
- Generates datapath write enables and a req/ack memory handshake with a timeout.
- Sits between the control decoder and the PC, IR, register file, ALU and memory interface.

---
 rtl/multicycle_seq_pkg.sv | 42 ++++
 rtl/multicycle_seq_if.sv | 23 ++
 rtl/multicycle_seq_mem_timeout_ctr.sv | 39 +++
 rtl/multicycle_seq.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_seq_pkg.sv
// Shared types and constants for the KGPminiRISC multi-cycle sequencer.
package multicycle_seq_pkg;

  // Debug-visible state encoding; values are fixed because software reads them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_e;

  localparam int unsigned OPW_DEF         = 6;
  localparam logic [5:0]  HALT_OPCODE_DEF = 6'b111111;

  // mem_addr_sel encodings
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  // Per-opcode control flags from the combinational decoder.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic cond_jump;
    logic uncond_jump;
  } dec_flags_t;

  // States in which a memory request is outstanding.
  function automatic logic is_mem_phase(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

  // States counted as busy: everything except IDLE and the two sticky stops.
  function automatic logic is_busy(input seq_state_e s);
    return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_FAULT));
  endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Memory request/acknowledge bus between the sequencer and the memory interface.
interface multicycle_seq_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  // Sequencer side issues requests and receives the ack pulse.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  // Memory side answers requests.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_seq_mem_timeout_ctr.sv
// Wait-cycle counter for a memory request: clear/enable with an expiry flag
// that goes high in the last cycle a request is allowed to wait.
module mem_timeout_ctr #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, saturate at the last allowed value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB from decoder flags, drives datapath write
// enables and a req/ack memory handshake with timeout.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int unsigned    OPW         = OPW_DEF,
  parameter logic [OPW-1:0] HALT_OPCODE = OPW'(HALT_OPCODE_DEF),
  parameter int unsigned    MEM_TIMEOUT = 16,
  parameter int unsigned    CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            dec_mem_read,
  input  logic            dec_mem_write,
  input  logic            dec_reg_write,
  input  logic            dec_cond_jump,
  input  logic            dec_uncond_jump,
  input  logic            alu_flag,
  multicycle_seq_if.master mem_bus,
  output logic            ir_we,
  output logic            pc_inc_we,
  output logic            pc_jump_we,
  output logic            alu_en,
  output logic            rf_we,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state,
  output logic [CNTW-1:0] instr_count
);

  seq_state_e      state_q, state_d;
  logic [CNTW-1:0] instr_count_q, instr_count_d;
  dec_flags_t      dec;
  logic            retire;
  logic            mem_phase;
  logic            tmo_clr;
  logic            tmo_en;
  logic            tmo_expired;
  logic            mem_ack;
  logic            mem_req_c;
  logic            mem_we_c;
  logic            mem_addr_sel_c;

  assign dec = '{
    mem_read:    dec_mem_read,
    mem_write:   dec_mem_write,
    reg_write:   dec_reg_write,
    cond_jump:   dec_cond_jump,
    uncond_jump: dec_uncond_jump
  };

  assign mem_ack   = mem_bus.mem_ack;
  assign mem_phase = is_mem_phase(state_q);

  // The counter is held clear outside FETCH/MEM and on the ack cycle, so it
  // is always zero on entry to either phase without decoding transitions.
  assign tmo_clr = !mem_phase || mem_ack;
  assign tmo_en  = mem_phase && !mem_ack;

  mem_timeout_ctr #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state selection, retire detection and retired-instruction count.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack)          state_d = ST_DECODE;
        else if (tmo_expired) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        if (opcode == HALT_OPCODE)           state_d = ST_HALT;
        else if (dec.mem_read && dec.mem_write) state_d = ST_FAULT;
        else                                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec.uncond_jump || dec.cond_jump) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (dec.mem_read || dec.mem_write) begin
          state_d = ST_MEM;
        end else if (dec.reg_write) begin
          state_d = ST_WB;
        end else begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (dec.mem_read) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (tmo_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
    endcase

    instr_count_d = retire ? (instr_count_q + 1'b1) : instr_count_q;
  end

  // Sequencer state and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Control outputs decoded from the current state plus ack / ALU flag.
  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = ADDR_PC;
    ir_we          = 1'b0;
    pc_inc_we      = 1'b0;
    pc_jump_we     = 1'b0;
    alu_en         = 1'b0;
    rf_we          = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = ADDR_PC;
        ir_we          = mem_ack;
        pc_inc_we      = mem_ack;
      end
      ST_EXEC: begin
        alu_en     = 1'b1;
        pc_jump_we = dec.uncond_jump || (dec.cond_jump && alu_flag);
      end
      ST_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = ADDR_ALU;
        mem_we_c       = dec.mem_write;
      end
      ST_WB:    rf_we  = 1'b1;
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign mem_bus.mem_req      = mem_req_c;
  assign mem_bus.mem_we       = mem_we_c;
  assign mem_bus.mem_addr_sel = mem_addr_sel_c;

  assign busy        = is_busy(state_q);
  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: randomized instruction stream with a
// per-instruction reference model, plus directed halt/fault/reset cases.
module tb_multicycle_seq;

  localparam int unsigned MT   = 16;
  localparam int unsigned CNTW = 8;

  localparam int C_ALU   = 0;
  localparam int C_LOAD  = 1;
  localparam int C_STORE = 2;
  localparam int C_BR    = 3;
  localparam int C_JMP   = 4;
  localparam int C_NOP   = 5;
  localparam int C_HALT  = 6;
  localparam int C_ILL   = 7;

  typedef struct {
    int cycles;
    int ir;
    int alu;
    int rf;
    int jmp;
    int memwe;
    int sel;
    int end_st;
    int count;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n, run, alu_flag;
  logic [5:0]      opcode;
  logic            d_rd, d_wr, d_rw, d_cj, d_uj;
  logic            ir_we, pc_inc_we, pc_jump_we, alu_en, rf_we, busy, halted, fault;
  logic [2:0]      state;
  logic [CNTW-1:0] instr_count;

  multicycle_seq_if mif ();

  multicycle_seq #(
    .OPW         (6),
    .HALT_OPCODE (6'b111111),
    .MEM_TIMEOUT (MT),
    .CNTW        (CNTW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .opcode          (opcode),
    .dec_mem_read    (d_rd),
    .dec_mem_write   (d_wr),
    .dec_reg_write   (d_rw),
    .dec_cond_jump   (d_cj),
    .dec_uncond_jump (d_uj),
    .alu_flag        (alu_flag),
    .mem_bus         (mif),
    .ir_we           (ir_we),
    .pc_inc_we       (pc_inc_we),
    .pc_jump_we      (pc_jump_we),
    .alu_en          (alu_en),
    .rf_we           (rf_we),
    .busy            (busy),
    .halted          (halted),
    .fault           (fault),
    .state           (state),
    .instr_count     (instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  logic [CNTW-1:0] exp_count = '0;
  bit mon_en = 1'b1;

  logic [5:0] p_op;
  logic       p_rd, p_wr, p_rw, p_cj, p_uj, p_af;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: what one instruction should look like end to end.
  function automatic exp_t model(input int cls, input int fd, input int md, input bit af);
    exp_t e;
    bit   ret;
    int   mc;
    e   = '{default: 0};
    ret = 1'b0;
    if (fd < 0) begin
      e.cycles = MT;
      e.end_st = 7;
    end else begin
      e.ir     = 1;
      e.cycles = fd + 2;
      if (cls == C_HALT) begin
        e.end_st = 6;
      end else if (cls == C_ILL) begin
        e.end_st = 7;
      end else begin
        e.alu = 1;
        e.cycles++;
        case (cls)
          C_ALU: begin e.rf = 1; e.cycles++; ret = 1'b1; end
          C_LOAD, C_STORE: begin
            mc = (md < 0) ? MT : md + 1;
            e.cycles += mc;
            e.sel = mc;
            if (cls == C_STORE) e.memwe = mc;
            if (md < 0) e.end_st = 7;
            else begin
              ret = 1'b1;
              if (cls == C_LOAD) begin e.rf = 1; e.cycles++; end
            end
          end
          C_BR:    begin e.jmp = af ? 1 : 0; ret = 1'b1; end
          C_JMP:   begin e.jmp = 1; ret = 1'b1; end
          default: ret = 1'b1;
        endcase
      end
    end
    if (ret) begin
      e.end_st = 1;
      exp_count++;
    end
    e.count = int'(exp_count);
    return e;
  endfunction

  task automatic set_fields(input int cls, input bit af);
    p_op = 6'($urandom_range(0, 62));
    p_rd = 0; p_wr = 0; p_rw = 0; p_cj = 0; p_uj = 0;
    p_af = af;
    case (cls)
      C_ALU:   p_rw = 1;
      C_LOAD:  begin p_rd = 1; p_rw = 1'($urandom_range(0, 1)); end
      C_STORE: p_wr = 1;
      C_BR:    begin p_cj = 1; p_rw = 1'($urandom_range(0, 1)); end
      C_JMP:   begin p_uj = 1; p_rw = 1'($urandom_range(0, 1)); p_cj = 1'($urandom_range(0, 1)); end
      C_HALT:  begin p_op = 6'b111111; p_rd = 1'($urandom_range(0, 1)); p_wr = p_rd; end
      C_ILL:   begin p_rd = 1; p_wr = 1; end
      default: ;
    endcase
  endtask

  // Play the memory: find the request, wait dly cycles, pulse ack.
  // dly < 0 never acks. Returns at the negedge after the ack cycle.
  task automatic serve(input int dly, input bit is_fetch);
    int w;
    w = 0;
    while (mif.mem_req !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL req_wait: mem_req not seen within 40 cycles at %0t", $time);
      return;
    end
    if (dly < 0) begin
      repeat (MT + 2) @(negedge clk);
      return;
    end
    repeat (dly) @(negedge clk);
    if (is_fetch) begin
      opcode = p_op; d_rd = p_rd; d_wr = p_wr; d_rw = p_rw;
      d_cj = p_cj; d_uj = p_uj; alu_flag = p_af;
    end
    mif.mem_ack = 1'b1;
    @(negedge clk);
    mif.mem_ack = 1'b0;
  endtask

  task automatic do_instr(input int cls, input int fd, input int md, input bit af);
    q.push_back(model(cls, fd, md, af));
    set_fields(cls, af);
    serve(fd, 1'b1);
    if (fd < 0) return;
    mif.mem_ack = 1'($urandom_range(0, 1));  // stray ack in DECODE
    @(negedge clk);
    mif.mem_ack = 1'b0;
    if (cls == C_LOAD || cls == C_STORE) serve(md, 1'b0);
  endtask

  function automatic int rnd_delay();
    if ($urandom_range(0, 9) == 0) return MT - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_outs"}, int'({mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, pc_inc_we,
                              pc_jump_we, alu_en, rf_we, busy, halted, fault}), 0);
    chk({tag, "_count"}, int'(instr_count), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; mif.mem_ack = 1'b0;
    @(negedge clk); #1;
    check_idle(tag);
    exp_count = '0;
    rst_n = 1'b1;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Monitor: accumulate each instruction's outputs and score it on completion.
  int a_cyc, a_ir, a_pinc, a_alu, a_rf, a_jmp, a_memwe, a_sel;
  int st, prev_st = 0;
  bit open = 1'b0;

  task automatic close_record(input int end_st);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: instruction completed with nothing expected at %0t", $time);
      return;
    end
    e = q.pop_front();
    chk("cycles", a_cyc, e.cycles);
    chk("ir_we", a_ir, e.ir);
    chk("pc_inc_we", a_pinc, e.ir);
    chk("alu_en", a_alu, e.alu);
    chk("rf_we", a_rf, e.rf);
    chk("pc_jump_we", a_jmp, e.jmp);
    chk("mem_we", a_memwe, e.memwe);
    chk("mem_addr_sel", a_sel, e.sel);
    chk("end_state", end_st, e.end_st);
    chk("instr_count", int'(instr_count), e.count);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      st = int'(state);
      if (!mon_en || !rst_n) begin
        open = 1'b0;
      end else begin
        if (open && st != prev_st && (st == 1 || st == 6 || st == 7)) begin
          close_record(st);
          open = 1'b0;
        end
        if (st == 1 && prev_st != 1) begin
          open = 1'b1;
          a_cyc = 0; a_ir = 0; a_pinc = 0; a_alu = 0;
          a_rf = 0; a_jmp = 0; a_memwe = 0; a_sel = 0;
        end
        if (open) begin
          a_cyc++;
          a_ir    += int'(ir_we);
          a_pinc  += int'(pc_inc_we);
          a_alu   += int'(alu_en);
          a_rf    += int'(rf_we);
          a_jmp   += int'(pc_jump_we);
          a_memwe += int'(mif.mem_req & mif.mem_we);
          a_sel   += int'(mif.mem_req & mif.mem_addr_sel);
        end
      end
      prev_st = st;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stim
    int cls;
    rst_n = 1'b0; run = 1'b0; alu_flag = 1'b0; opcode = '0;
    d_rd = 0; d_wr = 0; d_rw = 0; d_cj = 0; d_uj = 0;
    mif.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("idle_without_run", int'(state), 0);

    // Random stream long enough to wrap the retired counter, ending in HALT.
    start();
    for (int i = 0; i < 300; i++) begin
      cls = $urandom_range(C_ALU, C_NOP);
      do_instr(cls, rnd_delay(), rnd_delay(), 1'($urandom_range(0, 1)));
    end
    do_instr(C_HALT, rnd_delay(), 0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      chk("halt_state", int'(state), 6);
      chk("halted", int'(halted), 1);
      chk("halt_busy", int'(busy), 0);
    end
    do_reset("after_halt");

    // Fetch never acknowledged: FAULT in the 17th cycle after entering FETCH.
    start();
    do_instr(C_ALU, -1, 0, 1'b0);
    #1;
    chk("fetch_tmo_state", int'(state), 7);
    chk("fetch_tmo_fault", int'(fault), 1);
    chk("fetch_tmo_busy", int'(busy), 0);
    do_reset("after_fetch_tmo");

    // Load whose data phase is never acknowledged.
    start();
    do_instr(C_LOAD, 1, -1, 1'b0);
    #1;
    chk("mem_tmo_fault", int'(fault), 1);
    do_reset("after_mem_tmo");

    // Illegal decode: load and store flags together.
    start();
    do_instr(C_ALU, 0, 0, 1'b1);
    do_instr(C_ILL, 2, 0, 1'b0);
    @(negedge clk); #1;
    chk("illegal_fault", int'(fault), 1);
    do_reset("after_illegal");

    // Reset asserted while a load request is outstanding.
    mon_en = 1'b0;
    start();
    set_fields(C_LOAD, 1'b0);
    serve(0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("midmem_state", int'(state), 4);
    chk("midmem_req", int'(mif.mem_req), 1);
    chk("midmem_sel", int'(mif.mem_addr_sel), 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midmem_rst_state", int'(state), 0);
    chk("midmem_rst_req", int'(mif.mem_req), 0);
    rst_n = 1'b1;
    exp_count = '0;
    @(negedge clk);
    mon_en = 1'b1;

    // Short recovery stream after reset.
    start();
    for (int i = 0; i < 12; i++) begin
      do_instr($urandom_range(C_ALU, C_NOP), $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
    end
    do_instr(C_HALT, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
